// File: rtl/decode_unit_pkg.sv
// decode_unit_pkg: shared ID-stage definitions for decode_unit and the downstream EX stage.
//   Holds the MIPS opcode/funct codes, ALU operation codes, ID_CTRL bit positions,
//   the immediate-format selector and two small helpers used by the decoder.
package decode_unit_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_SLT  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_LUI  = 4'd7,
    ALU_PASS = 4'd8
  } alu_op_t;
  localparam int CTRL_LINK       = 0;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_ALU_LO     = 6;
  localparam int CTRL_ALU_HI     = 9;
  typedef enum logic [1:0] {IMM_SEXT, IMM_ZEXT, IMM_LUI, IMM_SHAMT} imm_kind_t;
  function automatic logic [31:0] make_imm(input imm_kind_t k, input logic [31:0] ins);
    return k == IMM_ZEXT  ? {16'h0, ins[15:0]} :
           k == IMM_LUI   ? {ins[15:0], 16'h0} :
           k == IMM_SHAMT ? {27'h0, ins[10:6]} :
                            {{16{ins[15]}}, ins[15:0]};
  endfunction
  // r0 never carries a value, so a producer targeting it is never a hazard.
  function automatic logic src_hit(input logic [4:0] d, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic use_rs, input logic use_rt);
    return d != 5'd0 && ((use_rs && d == rs) || (use_rt && d == rt));
  endfunction
endpackage

// File: rtl/decode_unit_regfile.sv
// decode_unit_regfile: 32x32 register file, two asynchronous read ports, one synchronous write port.
//   clk      in   clock, rising edge
//   ra, rb   in   read addresses;  qa, qb out  read data
//   wb_en    in   write enable;  wb_addr / wb_data  write address / data
//   r0 always reads 0 and ignores writes; a read of the register being written
//   this cycle returns the incoming data. Contents are not reset.
module decode_unit_regfile (
  input  logic        clk,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic [31:0] qa,
  output logic [31:0] qb,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data
);
  logic [31:0] mem [0:31];
  always_ff @(posedge clk)
    if (wb_en && wb_addr != 5'd0) mem[wb_addr] <= wb_data;
  assign qa = ra == 5'd0 ? 32'h0 : (wb_en && wb_addr == ra) ? wb_data : mem[ra];
  assign qb = rb == 5'd0 ? 32'h0 : (wb_en && wb_addr == rb) ? wb_data : mem[rb];
endmodule

// File: rtl/decode_unit.sv
// decode_unit: ID stage of the 5-stage MIPS pipeline.
//   Captures {pc, instr} from fetch into IF/ID, decodes it, reads the register file,
//   resolves jumps/branches in ID and registers a control+operand bundle for EX.
//   Inputs : clk, rst (sync, active-low), extend, pc, instr, wb_en/wb_addr/wb_data,
//            ex_mem_read, ex_wr_en, ex_dst, mem_mem_read, mem_dst
//   Outputs: dirty (stall), jump/target (redirect to fetch), id_valid, id_pc, id_ctrl,
//            id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_dst, illegal (one-cycle pulse)
module decode_unit
  import decode_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        extend,
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        ex_mem_read,
  input  logic        ex_wr_en,
  input  logic [4:0]  ex_dst,
  input  logic        mem_mem_read,
  input  logic [4:0]  mem_dst,
  output logic        dirty,
  output logic        jump,
  output logic [31:0] target,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [9:0]  id_ctrl,
  output logic [31:0] id_rs_data,
  output logic [31:0] id_rt_data,
  output logic [31:0] id_imm,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_dst,
  output logic        illegal
);
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_instr;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, dst;
  logic [31:0] rs_data, rt_data, pc4, sext, imm;
  alu_op_t     alu;
  imm_kind_t   imm_kind;
  logic        legal, reg_write, mem_read, mem_write, mem_to_reg, alu_src, link;
  logic        uses_rs, uses_rt, is_beq, is_bne, is_jr, is_j;
  logic        ctl, stall, take, issue;
  logic [9:0]  ctrl;
  assign op   = ifid_instr[31:26];
  assign rs   = ifid_instr[25:21];
  assign rt   = ifid_instr[20:16];
  assign rd   = ifid_instr[15:11];
  assign fn   = ifid_instr[5:0];
  assign pc4  = ifid_pc + 32'd4;
  assign sext = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
  assign imm  = make_imm(imm_kind, ifid_instr);
  decode_unit_regfile u_rf (
    .clk    (clk),
    .ra     (rs),
    .rb     (rt),
    .qa     (rs_data),
    .qb     (rt_data),
    .wb_en  (wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data)
  );
  always_comb begin
    legal      = 1'b1;
    alu        = ALU_PASS;
    imm_kind   = IMM_SEXT;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    link       = 1'b0;
    uses_rs    = 1'b1;
    uses_rt    = 1'b0;
    is_beq     = 1'b0;
    is_bne     = 1'b0;
    is_jr      = 1'b0;
    is_j       = 1'b0;
    dst        = rt;
    case (op)
      OP_RTYPE: begin
        uses_rt   = 1'b1;
        reg_write = 1'b1;
        dst       = rd;
        case (fn)
          FN_ADD: alu = ALU_ADD;
          FN_SUB: alu = ALU_SUB;
          FN_AND: alu = ALU_AND;
          FN_OR:  alu = ALU_OR;
          FN_SLT: alu = ALU_SLT;
          FN_SLL: begin alu = ALU_SLL; alu_src = 1'b1; imm_kind = IMM_SHAMT; end
          FN_SRL: begin alu = ALU_SRL; alu_src = 1'b1; imm_kind = IMM_SHAMT; end
          FN_JR:  begin reg_write = 1'b0; uses_rt = 1'b0; is_jr = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin alu = ALU_ADD; reg_write = 1'b1; alu_src = 1'b1; end
      OP_SLTI: begin alu = ALU_SLT; reg_write = 1'b1; alu_src = 1'b1; end
      OP_ANDI: begin alu = ALU_AND; reg_write = 1'b1; alu_src = 1'b1; imm_kind = IMM_ZEXT; end
      OP_ORI:  begin alu = ALU_OR;  reg_write = 1'b1; alu_src = 1'b1; imm_kind = IMM_ZEXT; end
      OP_LUI:  begin alu = ALU_LUI; reg_write = 1'b1; alu_src = 1'b1; imm_kind = IMM_LUI; uses_rs = 1'b0; end
      OP_LW: begin
        alu        = ALU_ADD;
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 1'b1;
      end
      OP_SW:  begin alu = ALU_ADD; mem_write = 1'b1; alu_src = 1'b1; uses_rt = 1'b1; end
      OP_BEQ: begin alu = ALU_SUB; uses_rt = 1'b1; is_beq = 1'b1; end
      OP_BNE: begin alu = ALU_SUB; uses_rt = 1'b1; is_bne = 1'b1; end
      OP_J:   begin is_j = 1'b1; uses_rs = 1'b0; end
      OP_JAL: begin is_j = 1'b1; uses_rs = 1'b0; reg_write = 1'b1; link = 1'b1; dst = 5'd31; end
      default: legal = 1'b0;
    endcase
    // an undecodable word reads nothing, so it can never stall
    if (!legal) begin
      uses_rs   = 1'b0;
      uses_rt   = 1'b0;
      reg_write = 1'b0;
    end
  end
  always_comb begin
    ctrl                             = '0;
    ctrl[CTRL_ALU_HI:CTRL_ALU_LO]    = alu;
    ctrl[CTRL_REG_WRITE]             = reg_write;
    ctrl[CTRL_MEM_READ]              = mem_read;
    ctrl[CTRL_MEM_WRITE]             = mem_write;
    ctrl[CTRL_MEM_TO_REG]            = mem_to_reg;
    ctrl[CTRL_ALU_SRC]               = alu_src;
    ctrl[CTRL_LINK]                  = link;
  end
  // Load-use always stalls; control transfers resolved in ID additionally wait
  // for any EX producer and for a MEM-stage load, since nothing is forwarded here.
  assign ctl   = is_beq || is_bne || is_jr;
  assign stall = ifid_valid && (
                   (ex_mem_read && src_hit(ex_dst, rs, rt, uses_rs, uses_rt)) ||
                   (ctl && ex_wr_en && src_hit(ex_dst, rs, rt, uses_rs, uses_rt)) ||
                   (ctl && mem_mem_read && src_hit(mem_dst, rs, rt, uses_rs, uses_rt)));
  assign take   = is_j || is_jr || (is_beq && rs_data == rt_data) || (is_bne && rs_data != rt_data);
  assign dirty  = stall;
  assign jump   = ifid_valid && !stall && take;
  assign target = is_jr ? rs_data :
                  is_j  ? {pc4[31:28], ifid_instr[25:0], 2'b00} :
                          pc4 + {sext[29:0], 2'b00};
  assign issue  = ifid_valid && !stall && legal;
  always_ff @(posedge clk) begin
    if (!rst) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= RESET_PC;
      ifid_instr <= 32'h0;
    end else if (!dirty) begin
      ifid_valid <= !extend && !jump;
      ifid_pc    <= pc;
      ifid_instr <= instr;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      id_valid   <= 1'b0;
      id_pc      <= RESET_PC;
      id_ctrl    <= '0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imm     <= '0;
      id_rs      <= '0;
      id_rt      <= '0;
      id_dst     <= '0;
      illegal    <= 1'b0;
    end else begin
      id_valid   <= issue;
      id_pc      <= ifid_pc;
      id_ctrl    <= issue ? ctrl : '0;
      id_rs_data <= link ? pc4 : rs_data;
      id_rt_data <= rt_data;
      id_imm     <= imm;
      id_rs      <= rs;
      id_rt      <= rt;
      id_dst     <= reg_write ? dst : 5'd0;
      illegal    <= ifid_valid && !stall && !legal;
    end
  end
endmodule

// File: tb/tb_decode_unit.sv
// tb_decode_unit: table-driven check of decode_unit plus hand sequences for stalls, reset and r0.
module tb_decode_unit;
  logic        clk = 1'b0;
  logic        rst, extend, wb_en, ex_mem_read, ex_wr_en, mem_mem_read;
  logic [31:0] pc, instr, wb_data, target, id_pc, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  wb_addr, ex_dst, mem_dst, id_rs, id_rt, id_dst;
  logic        dirty, jump, id_valid, illegal;
  logic [9:0]  id_ctrl;
  int errors = 0;
  int checks = 0;
  logic [31:0] mdl [0:31];
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic [9:0]  ctrl;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
    logic [31:0] imm;
    logic [4:0]  dst;
    logic        jmp;
    logic [31:0] tgt;
  } vec_t;
  vec_t v [16];
  decode_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .extend(extend), .pc(pc), .instr(instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_mem_read(ex_mem_read), .ex_wr_en(ex_wr_en), .ex_dst(ex_dst),
    .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .dirty(dirty), .jump(jump), .target(target), .id_valid(id_valid), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_dst(id_dst), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h1000 + 32'(i) * 4;
    mdl[0] = 32'h0;
    mdl[1] = 32'd5;
    mdl[3] = 32'd9;
    mdl[4] = 32'd9;
    v[0]  = '{32'h10, 32'h20220007, 1, 10'h022, 32'd5,   mdl[2],  32'd7,        5'd2,  0, 32'h0};
    v[1]  = '{32'h20, 32'h10640004, 1, 10'h040, 32'd9,   32'd9,   32'd4,        5'd0,  1, 32'h34};
    v[2]  = '{32'h30, 32'h1464FFFE, 1, 10'h040, 32'd9,   32'd9,   32'hFFFFFFFE, 5'd0,  0, 32'h0};
    v[3]  = '{32'h30, 32'h1423FFFE, 1, 10'h040, 32'd5,   32'd9,   32'hFFFFFFFE, 5'd0,  1, 32'h2C};
    v[4]  = '{32'h40, 32'h0C000100, 1, 10'h221, 32'h44,  32'h0,   32'h100,      5'd31, 1, 32'h400};
    v[5]  = '{32'hFFFFFFFC, 32'h0BFFFFFF, 1, 10'h200, mdl[31], mdl[31], 32'hFFFFFFFF, 5'd0, 1, 32'h0FFFFFFC};
    v[6]  = '{32'h50, 32'h01200008, 1, 10'h200, mdl[9],  32'h0,   32'd8,        5'd0,  1, mdl[9]};
    v[7]  = '{32'h54, 32'h000428C0, 1, 10'h162, 32'h0,   32'd9,   32'd3,        5'd5,  0, 32'h0};
    v[8]  = '{32'h58, 32'h3C081234, 1, 10'h1E2, 32'h0,   mdl[8],  32'h12340000, 5'd8,  0, 32'h0};
    v[9]  = '{32'h5C, 32'h30AA8001, 1, 10'h0A2, mdl[5],  mdl[10], 32'h00008001, 5'd10, 0, 32'h0};
    v[10] = '{32'h60, 32'h8C2BFFFC, 1, 10'h036, 32'd5,   mdl[11], 32'hFFFFFFFC, 5'd11, 0, 32'h0};
    v[11] = '{32'h64, 32'hAC830008, 1, 10'h00A, 32'd9,   32'd9,   32'd8,        5'd0,  0, 32'h0};
    v[12] = '{32'h68, 32'hFC000000, 0, 10'h000, 32'h0,   32'h0,   32'h0,        5'd0,  0, 32'h0};
    v[13] = '{32'h6C, 32'h0000003F, 0, 10'h000, 32'h0,   32'h0,   32'h0,        5'd0,  0, 32'h0};
    v[14] = '{32'h70, 32'h00616022, 1, 10'h060, 32'd9,   32'd5,   32'h6022,     5'd12, 0, 32'h0};
    v[15] = '{32'h74, 32'h0023682A, 1, 10'h120, 32'd5,   32'd9,   32'h682A,     5'd13, 0, 32'h0};
    rst = 1'b0; extend = 1'b1; pc = 32'h0; instr = 32'h0;
    wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
    ex_mem_read = 1'b0; ex_wr_en = 1'b0; ex_dst = 5'd0; mem_mem_read = 1'b0; mem_dst = 5'd0;
    tick();
    tick();
    chk("reset id_valid", id_valid, 0);
    chk("reset id_pc", id_pc, 32'h0);
    chk("reset id_ctrl", id_ctrl, 0);
    chk("reset illegal", illegal, 0);
    chk("reset dirty", dirty, 0);
    chk("reset jump", jump, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("extend id_valid", id_valid, 0);
      chk("extend dirty", dirty, 0);
      chk("extend jump", jump, 0);
    end
    for (int i = 1; i < 32; i++) begin
      wb_en = 1'b1; wb_addr = 5'(i); wb_data = mdl[i];
      tick();
    end
    wb_en = 1'b0;
    extend = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pc = v[i].pc; instr = v[i].instr;
      tick();
      chk($sformatf("v%0d dirty", i), dirty, 0);
      chk($sformatf("v%0d jump", i), jump, v[i].jmp);
      if (v[i].jmp) chk($sformatf("v%0d target", i), target, v[i].tgt);
      pc = v[i].pc + 32'd4; instr = 32'h0;
      tick();
      chk($sformatf("v%0d illegal", i), illegal, !v[i].valid);
      chk($sformatf("v%0d id_valid", i), id_valid, v[i].valid);
      chk($sformatf("v%0d id_ctrl", i), id_ctrl, v[i].ctrl);
      if (v[i].valid) begin
        chk($sformatf("v%0d id_pc", i), id_pc, v[i].pc);
        chk($sformatf("v%0d id_rs_data", i), id_rs_data, v[i].rs_d);
        chk($sformatf("v%0d id_rt_data", i), id_rt_data, v[i].rt_d);
        chk($sformatf("v%0d id_imm", i), id_imm, v[i].imm);
        chk($sformatf("v%0d id_dst", i), id_dst, v[i].dst);
      end
      tick();
      chk($sformatf("v%0d illegal pulse end", i), illegal, 0);
      chk($sformatf("v%0d next slot valid", i), id_valid, !v[i].jmp);
    end
    // load-use stall: add r7,r6,r1 behind a lw to r6
    pc = 32'h80; instr = 32'h00C13820; ex_mem_read = 1'b1; ex_dst = 5'd6;
    tick();
    chk("lu dirty", dirty, 1);
    chk("lu jump", jump, 0);
    pc = 32'h84; instr = 32'h0;
    tick();
    chk("lu bubble valid", id_valid, 0);
    chk("lu bubble ctrl", id_ctrl, 0);
    ex_mem_read = 1'b0;
    #1;
    chk("lu released", dirty, 0);
    tick();
    chk("lu add valid", id_valid, 1);
    chk("lu add pc", id_pc, 32'h80);
    chk("lu add rs", id_rs_data, mdl[6]);
    chk("lu add rt", id_rt_data, 32'd5);
    chk("lu add dst", id_dst, 5'd7);
    chk("lu add ctrl", id_ctrl, 10'h020);
    // branch waits for EX producer and MEM load
    pc = 32'h90; instr = 32'h10640004; ex_wr_en = 1'b1; ex_dst = 5'd3;
    tick();
    chk("br ex dirty", dirty, 1);
    chk("br ex jump", jump, 0);
    ex_wr_en = 1'b0; mem_mem_read = 1'b1; mem_dst = 5'd4;
    #1;
    chk("br mem dirty", dirty, 1);
    mem_mem_read = 1'b0;
    #1;
    chk("br clear dirty", dirty, 0);
    chk("br clear jump", jump, 1);
    chk("br clear target", target, 32'hA4);
    instr = 32'h0;
    tick();
    tick();
    // r0 write ignored; lw to r0 in EX does not stall
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0;
    pc = 32'hB0; instr = 32'h20020001; ex_mem_read = 1'b1; ex_dst = 5'd0;
    tick();
    chk("r0 no stall", dirty, 0);
    ex_mem_read = 1'b0; instr = 32'h0;
    tick();
    chk("r0 reads 0", id_rs_data, 32'h0);
    // write-through: r1 written in the same cycle it is read
    pc = 32'hC0; instr = 32'h20220000;
    tick();
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'h77; instr = 32'h0;
    tick();
    wb_en = 1'b0;
    chk("write-through", id_rs_data, 32'h77);
    // reset asserted mid-stall
    pc = 32'hD0; instr = 32'h00C13820; ex_mem_read = 1'b1; ex_dst = 5'd6;
    tick();
    chk("rs stall dirty", dirty, 1);
    rst = 1'b0;
    tick();
    chk("rs dirty", dirty, 0);
    chk("rs jump", jump, 0);
    chk("rs id_valid", id_valid, 0);
    chk("rs id_ctrl", id_ctrl, 0);
    chk("rs id_pc", id_pc, 32'h0);
    chk("rs id_rs_data", id_rs_data, 32'h0);
    chk("rs id_dst", id_dst, 0);
    chk("rs illegal", illegal, 0);
    rst = 1'b1; ex_mem_read = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
